instruction_fetch_unit: RTL

Fetch stage that produces the instruction stream for the IF/ID pipeline register. It holds the fetch PC and issues single-outstanding requests to instruction memory over a req/valid handshake. Returned words go into a small prefetch FIFO whose head drives `PR0_instruction`/`PR0_PC_plus1`. The FIFO pops when IF/ID accepts (`write_en`), and the unit redirects and squashes on a taken branch (the same event that flushes IF/ID).

---
 rtl/instruction_fetch_unit.sv | 108 ++++++++++
 1 files changed

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: single-outstanding fetch engine feeding a first-word fall-through prefetch FIFO.
`ifndef ADDRESS_LEN
`define ADDRESS_LEN 16
`endif
`ifndef INSTRUCTION_LEN
`define INSTRUCTION_LEN 32
`endif

module instruction_fetch_unit #(
    parameter logic [`ADDRESS_LEN-1:0] RESET_PC = '0,
    parameter int DEPTH = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        write_en,
    input  logic                        branch_taken,
    input  logic [`ADDRESS_LEN-1:0]     branch_target,
    output logic                        imem_req,
    output logic [`ADDRESS_LEN-1:0]     imem_addr,
    input  logic                        imem_valid,
    input  logic [`INSTRUCTION_LEN-1:0] imem_rdata,
    output logic [`INSTRUCTION_LEN-1:0] PR0_instruction,
    output logic [`ADDRESS_LEN-1:0]     PR0_PC_plus1,
    output logic                        fetch_valid
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, FULL} state_t;
    state_t state;

    logic [`ADDRESS_LEN-1:0]     fetch_pc;
    logic [`ADDRESS_LEN-1:0]     pc_mem [DEPTH];
    logic [`INSTRUCTION_LEN-1:0] ins_mem [DEPTH];
    logic [AW-1:0]               rd_ptr, wr_ptr;
    logic [CW-1:0]               count, count_next;
    logic                        squash, push, pop;

    assign pop = write_en && count != '0 && !branch_taken;
    assign push = state == REQ && imem_valid && !squash && !branch_taken;
    assign count_next = count + CW'(push) - CW'(pop);

    // Head is driven from registered state only, so empty reads as a NOP bubble.
    assign fetch_valid = count != '0;
    assign PR0_instruction = fetch_valid ? ins_mem[rd_ptr] : '0;
    assign PR0_PC_plus1 = fetch_valid ? pc_mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr] <= imem_addr + 1'b1;
            ins_mem[wr_ptr] <= imem_rdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            fetch_pc <= RESET_PC;
            squash <= 1'b0;
            imem_req <= 1'b0;
            imem_addr <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count <= '0;
        end else if (branch_taken) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count <= '0;
            fetch_pc <= branch_target;
            // An in-flight request cannot be cancelled; its response is dropped later.
            if (state == REQ && !imem_valid) begin
                squash <= 1'b1;
            end else begin
                squash <= 1'b0;
                state <= REQ;
                imem_req <= 1'b1;
                imem_addr <= branch_target;
            end
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count_next;
            if (state == IDLE) begin
                state <= REQ;
                imem_req <= 1'b1;
                imem_addr <= fetch_pc;
            end else if (state == FULL) begin
                if (pop) begin
                    state <= REQ;
                    imem_req <= 1'b1;
                    imem_addr <= fetch_pc;
                end
            end else if (imem_valid && squash) begin
                squash <= 1'b0;
                imem_addr <= fetch_pc;
            end else if (push) begin
                fetch_pc <= fetch_pc + 1'b1;
                if (count_next < DEPTH_C) begin
                    imem_addr <= fetch_pc + 1'b1;
                end else begin
                    state <= FULL;
                    imem_req <= 1'b0;
                end
            end
        end
    end
endmodule
